// File: rtl/reservation_station_param.sv
// Age-ordered reservation station sitting between dispatch and one functional unit.
// Entries capture operand values from ROB broadcasts. Each cycle the oldest entry
// whose operands are both valid is offered to the FU through a valid/ready handshake.
// Ages run from 0 for the youngest entry up to count-1 for the oldest, so the
// ages of the live entries are always unique.

module reservation_station_param #(
    parameter int RS_SIZE      = 8,
    parameter int ROB_IDX_SIZE = 5,
    parameter int GPR_SIZE     = 64,
    parameter int CTRL_WIDTH   = 8,
    localparam int IDX_W       = $clog2(RS_SIZE)
) (
    input  logic                    in_clk,
    input  logic                    in_rst,

    input  logic                    in_dispatch_valid,
    output logic                    out_dispatch_ready,
    input  logic                    in_op1_valid,
    input  logic                    in_op2_valid,
    input  logic [ROB_IDX_SIZE-1:0] in_op1_rob_index,
    input  logic [ROB_IDX_SIZE-1:0] in_op2_rob_index,
    input  logic [GPR_SIZE-1:0]     in_op1_value,
    input  logic [GPR_SIZE-1:0]     in_op2_value,
    input  logic [ROB_IDX_SIZE-1:0] in_dst_rob_index,
    input  logic                    in_set_nzcv,
    input  logic [CTRL_WIDTH-1:0]   in_ctrl,

    input  logic                    in_rob_broadcast_done,
    input  logic [ROB_IDX_SIZE-1:0] in_rob_broadcast_index,
    input  logic [GPR_SIZE-1:0]     in_rob_broadcast_val,
    input  logic                    in_rob_is_mispred,

    input  logic                    in_fu_ready,
    output logic                    out_issue_valid,
    output logic [GPR_SIZE-1:0]     out_issue_op1_value,
    output logic [GPR_SIZE-1:0]     out_issue_op2_value,
    output logic [ROB_IDX_SIZE-1:0] out_issue_dst_rob_index,
    output logic                    out_issue_set_nzcv,
    output logic [CTRL_WIDTH-1:0]   out_issue_ctrl,
    output logic [IDX_W:0]          out_count
);

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(RS_SIZE);

    logic [RS_SIZE-1:0]      entry_valid;
    logic [RS_SIZE-1:0]      op1_valid;
    logic [RS_SIZE-1:0]      op2_valid;
    logic [ROB_IDX_SIZE-1:0] op1_tag [RS_SIZE];
    logic [ROB_IDX_SIZE-1:0] op2_tag [RS_SIZE];
    logic [GPR_SIZE-1:0]     op1_val [RS_SIZE];
    logic [GPR_SIZE-1:0]     op2_val [RS_SIZE];
    logic [ROB_IDX_SIZE-1:0] dst_tag [RS_SIZE];
    logic [RS_SIZE-1:0]      nzcv;
    logic [CTRL_WIDTH-1:0]   ctrl    [RS_SIZE];
    logic [IDX_W-1:0]        age     [RS_SIZE];
    logic [IDX_W:0]          count;

    logic [RS_SIZE-1:0]      entry_ready;
    logic                    sel_found;
    logic [IDX_W-1:0]        sel_idx;
    logic [IDX_W-1:0]        sel_age;
    logic [IDX_W-1:0]        alloc_idx;
    logic                    disp_fire;
    logic                    issue_valid;
    logic                    issue_fire;
    logic                    disp_op1_valid;
    logic                    disp_op2_valid;
    logic [GPR_SIZE-1:0]     disp_op1_value;
    logic [GPR_SIZE-1:0]     disp_op2_value;

    assign entry_ready        = entry_valid & op1_valid & op2_valid;
    assign out_dispatch_ready = (count < FULL_COUNT);
    assign disp_fire          = in_dispatch_valid & out_dispatch_ready & ~in_rob_is_mispred;
    assign issue_valid        = sel_found & ~in_rob_is_mispred;
    assign issue_fire         = issue_valid & in_fu_ready;
    assign out_count          = count;

    // Pick the ready entry with the largest age; strict compare keeps the lowest index on ties
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (entry_ready[i] && (!sel_found || (age[i] > sel_age))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age[i];
            end
        end
    end

    // Lowest-index free slot for a new dispatch
    always_comb begin
        alloc_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!entry_valid[i]) begin
                alloc_idx = IDX_W'(i);
            end
        end
    end

    // Dispatched operands that miss their value pick it up from a same-cycle broadcast
    always_comb begin
        disp_op1_valid = in_op1_valid |
                         (in_rob_broadcast_done && (in_op1_rob_index == in_rob_broadcast_index));
        disp_op2_valid = in_op2_valid |
                         (in_rob_broadcast_done && (in_op2_rob_index == in_rob_broadcast_index));
        disp_op1_value = in_op1_valid ? in_op1_value : in_rob_broadcast_val;
        disp_op2_value = in_op2_valid ? in_op2_value : in_rob_broadcast_val;
    end

    // Entry storage: allocate, issue, wakeup and age bookkeeping.
    // When an entry issues, every entry older than it moves down by one. Without
    // that step, a long-waiting entry could keep aging past the counter width
    // while younger entries issue around it.
    always_ff @(posedge in_clk) begin
        if (in_rst || in_rob_is_mispred) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entry_valid[i] <= 1'b0;
                age[i]         <= '0;
            end
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (disp_fire && (alloc_idx == IDX_W'(i))) begin
                    entry_valid[i] <= 1'b1;
                    age[i]         <= '0;
                    op1_valid[i]   <= disp_op1_valid;
                    op2_valid[i]   <= disp_op2_valid;
                    op1_tag[i]     <= in_op1_rob_index;
                    op2_tag[i]     <= in_op2_rob_index;
                    op1_val[i]     <= disp_op1_value;
                    op2_val[i]     <= disp_op2_value;
                    dst_tag[i]     <= in_dst_rob_index;
                    nzcv[i]        <= in_set_nzcv;
                    ctrl[i]        <= in_ctrl;
                end else if (entry_valid[i]) begin
                    if (issue_fire && (sel_idx == IDX_W'(i))) begin
                        entry_valid[i] <= 1'b0;
                    end else begin
                        age[i] <= age[i] + IDX_W'(disp_fire)
                                         - IDX_W'(issue_fire && (age[i] > sel_age));
                        if (in_rob_broadcast_done && !op1_valid[i] &&
                            (op1_tag[i] == in_rob_broadcast_index)) begin
                            op1_valid[i] <= 1'b1;
                            op1_val[i]   <= in_rob_broadcast_val;
                        end
                        if (in_rob_broadcast_done && !op2_valid[i] &&
                            (op2_tag[i] == in_rob_broadcast_index)) begin
                            op2_valid[i] <= 1'b1;
                            op2_val[i]   <= in_rob_broadcast_val;
                        end
                    end
                end
            end
        end
    end

    // Occupancy counter; a dispatch and an issue on the same edge cancel out
    always_ff @(posedge in_clk) begin
        if (in_rst || in_rob_is_mispred) begin
            count <= '0;
        end else begin
            case ({disp_fire, issue_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue payload of the selected entry, forced to zero when nothing is offered
    always_comb begin
        out_issue_valid         = issue_valid;
        out_issue_op1_value     = '0;
        out_issue_op2_value     = '0;
        out_issue_dst_rob_index = '0;
        out_issue_set_nzcv      = 1'b0;
        out_issue_ctrl          = '0;
        if (issue_valid) begin
            out_issue_op1_value     = op1_val[sel_idx];
            out_issue_op2_value     = op2_val[sel_idx];
            out_issue_dst_rob_index = dst_tag[sel_idx];
            out_issue_set_nzcv      = nzcv[sel_idx];
            out_issue_ctrl          = ctrl[sel_idx];
        end
    end

endmodule

// File: tb/tb_reservation_station_param.sv
// Directed bench for a 4-entry reservation station. Inputs change 1 ns after
// each rising edge, and outputs are checked 1 ns after that.

module tb_reservation_station_param;

    localparam int RS_SIZE = 4;
    localparam int RW      = 5;
    localparam int GW      = 64;
    localparam int CW      = 8;
    localparam int IW      = $clog2(RS_SIZE);

    logic          in_clk = 1'b0;
    logic          in_rst;
    logic          in_dispatch_valid;
    logic          out_dispatch_ready;
    logic          in_op1_valid, in_op2_valid;
    logic [RW-1:0] in_op1_rob_index, in_op2_rob_index;
    logic [GW-1:0] in_op1_value, in_op2_value;
    logic [RW-1:0] in_dst_rob_index;
    logic          in_set_nzcv;
    logic [CW-1:0] in_ctrl;
    logic          in_rob_broadcast_done;
    logic [RW-1:0] in_rob_broadcast_index;
    logic [GW-1:0] in_rob_broadcast_val;
    logic          in_rob_is_mispred;
    logic          in_fu_ready;
    logic          out_issue_valid;
    logic [GW-1:0] out_issue_op1_value, out_issue_op2_value;
    logic [RW-1:0] out_issue_dst_rob_index;
    logic          out_issue_set_nzcv;
    logic [CW-1:0] out_issue_ctrl;
    logic [IW:0]   out_count;

    int compared   = 0;
    int mismatched = 0;

    reservation_station_param #(
        .RS_SIZE(RS_SIZE), .ROB_IDX_SIZE(RW), .GPR_SIZE(GW), .CTRL_WIDTH(CW)
    ) dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_dispatch_valid(in_dispatch_valid), .out_dispatch_ready(out_dispatch_ready),
        .in_op1_valid(in_op1_valid), .in_op2_valid(in_op2_valid),
        .in_op1_rob_index(in_op1_rob_index), .in_op2_rob_index(in_op2_rob_index),
        .in_op1_value(in_op1_value), .in_op2_value(in_op2_value),
        .in_dst_rob_index(in_dst_rob_index), .in_set_nzcv(in_set_nzcv), .in_ctrl(in_ctrl),
        .in_rob_broadcast_done(in_rob_broadcast_done),
        .in_rob_broadcast_index(in_rob_broadcast_index),
        .in_rob_broadcast_val(in_rob_broadcast_val),
        .in_rob_is_mispred(in_rob_is_mispred), .in_fu_ready(in_fu_ready),
        .out_issue_valid(out_issue_valid),
        .out_issue_op1_value(out_issue_op1_value), .out_issue_op2_value(out_issue_op2_value),
        .out_issue_dst_rob_index(out_issue_dst_rob_index),
        .out_issue_set_nzcv(out_issue_set_nzcv), .out_issue_ctrl(out_issue_ctrl),
        .out_count(out_count)
    );

    always #5 in_clk = ~in_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge in_clk);
        #1;
    endtask

    task automatic idle();
        in_rst                 = 1'b0;
        in_dispatch_valid      = 1'b0;
        in_op1_valid           = 1'b0;
        in_op2_valid           = 1'b0;
        in_op1_rob_index       = '0;
        in_op2_rob_index       = '0;
        in_op1_value           = '0;
        in_op2_value           = '0;
        in_dst_rob_index       = '0;
        in_set_nzcv            = 1'b0;
        in_ctrl                = '0;
        in_rob_broadcast_done  = 1'b0;
        in_rob_broadcast_index = '0;
        in_rob_broadcast_val   = '0;
        in_rob_is_mispred      = 1'b0;
        in_fu_ready            = 1'b0;
    endtask

    task automatic disp(input logic v1, input logic [RW-1:0] t1, input logic [GW-1:0] x1,
                        input logic v2, input logic [RW-1:0] t2, input logic [GW-1:0] x2,
                        input logic [RW-1:0] dst, input logic nz, input logic [CW-1:0] c);
        in_dispatch_valid = 1'b1;
        in_op1_valid      = v1;
        in_op1_rob_index  = t1;
        in_op1_value      = x1;
        in_op2_valid      = v2;
        in_op2_rob_index  = t2;
        in_op2_value      = x2;
        in_dst_rob_index  = dst;
        in_set_nzcv       = nz;
        in_ctrl           = c;
    endtask

    task automatic bcast(input logic [RW-1:0] t, input logic [GW-1:0] v);
        in_rob_broadcast_done  = 1'b1;
        in_rob_broadcast_index = t;
        in_rob_broadcast_val   = v;
    endtask

    initial begin
        idle();
        in_rst = 1'b1;
        cyc();
        cyc();
        #1;
        chk("rst_count", 64'(out_count), 64'd0);
        chk("rst_issue_valid", 64'(out_issue_valid), 64'd0);
        chk("rst_issue_op1", out_issue_op1_value, 64'd0);
        chk("rst_issue_dst", 64'(out_issue_dst_rob_index), 64'd0);
        chk("rst_disp_ready", 64'(out_dispatch_ready), 64'd1);

        // Single ready entry A
        cyc(); idle();
        disp(1, 0, 64'd5, 1, 0, 64'd7, 5'd3, 1'b1, 8'h21);
        in_fu_ready = 1'b1;
        #1;
        chk("a_no_issue_same_cycle", 64'(out_issue_valid), 64'd0);
        cyc(); idle(); in_fu_ready = 1'b1; #1;
        chk("a_issue_valid", 64'(out_issue_valid), 64'd1);
        chk("a_op1", out_issue_op1_value, 64'd5);
        chk("a_op2", out_issue_op2_value, 64'd7);
        chk("a_dst", 64'(out_issue_dst_rob_index), 64'd3);
        chk("a_nzcv", 64'(out_issue_set_nzcv), 64'd1);
        chk("a_ctrl", 64'(out_issue_ctrl), 64'h21);
        chk("a_count", 64'(out_count), 64'd1);
        cyc(); idle(); #1;
        chk("a_count_after", 64'(out_count), 64'd0);
        chk("a_valid_after", 64'(out_issue_valid), 64'd0);

        // Fill with four entries whose op1 waits on tag 9
        for (int k = 0; k < 4; k++) begin
            cyc(); idle();
            disp(0, 5'd9, 64'd0, 1, 0, 64'(k + 1), 5'(10 + k), 1'b0, 8'(k));
            #1;
        end
        cyc(); idle(); #1;
        chk("full_count", 64'(out_count), 64'd4);
        chk("full_ready", 64'(out_dispatch_ready), 64'd0);
        chk("full_no_issue", 64'(out_issue_valid), 64'd0);
        disp(1, 0, 64'h99, 1, 0, 64'h98, 5'd20, 1'b0, 8'h0);
        cyc(); idle(); #1;
        chk("full_5th_ignored", 64'(out_count), 64'd4);
        bcast(5'd9, 64'hAA);
        cyc(); idle(); in_fu_ready = 1'b1; #1;
        chk("drain0_valid", 64'(out_issue_valid), 64'd1);
        chk("drain0_dst", 64'(out_issue_dst_rob_index), 64'd10);
        chk("drain0_op1", out_issue_op1_value, 64'hAA);
        chk("drain0_op2", out_issue_op2_value, 64'd1);
        chk("drain0_ready_while_full", 64'(out_dispatch_ready), 64'd0);
        for (int k = 1; k < 4; k++) begin
            cyc(); idle(); in_fu_ready = 1'b1; #1;
            chk("drain_dst", 64'(out_issue_dst_rob_index), 64'(10 + k));
            chk("drain_op1", out_issue_op1_value, 64'hAA);
            chk("drain_op2", out_issue_op2_value, 64'(k + 1));
            chk("drain_count", 64'(out_count), 64'(4 - k));
            chk("drain_disp_ready", 64'(out_dispatch_ready), 64'd1);
        end
        cyc(); idle(); #1;
        chk("drain_empty_count", 64'(out_count), 64'd0);
        chk("drain_empty_valid", 64'(out_issue_valid), 64'd0);

        // Older X waits on tag 2, younger Y is ready
        disp(0, 5'd2, 64'd0, 1, 0, 64'h22, 5'd1, 1'b0, 8'h0);
        cyc(); idle();
        disp(1, 0, 64'h33, 1, 0, 64'h44, 5'd2, 1'b0, 8'h0);
        cyc(); idle(); in_fu_ready = 1'b1; #1;
        chk("xy_first_dst", 64'(out_issue_dst_rob_index), 64'd2);
        chk("xy_first_op1", out_issue_op1_value, 64'h33);
        chk("xy_count", 64'(out_count), 64'd2);
        cyc(); idle(); in_fu_ready = 1'b1; bcast(5'd2, 64'h55); #1;
        chk("xy_x_not_yet", 64'(out_issue_valid), 64'd0);
        cyc(); idle(); in_fu_ready = 1'b1; #1;
        chk("xy_x_valid", 64'(out_issue_valid), 64'd1);
        chk("xy_x_dst", 64'(out_issue_dst_rob_index), 64'd1);
        chk("xy_x_op1", out_issue_op1_value, 64'h55);
        chk("xy_x_op2", out_issue_op2_value, 64'h22);
        cyc(); idle(); #1;
        chk("xy_count_after", 64'(out_count), 64'd0);

        // Dispatch-time bypass of a same-cycle broadcast
        disp(1, 0, 64'h9, 0, 5'd6, 64'd0, 5'd7, 1'b0, 8'h0);
        bcast(5'd6, 64'h1234);
        cyc(); idle(); in_fu_ready = 1'b1; #1;
        chk("byp_valid", 64'(out_issue_valid), 64'd1);
        chk("byp_op2", out_issue_op2_value, 64'h1234);
        chk("byp_dst", 64'(out_issue_dst_rob_index), 64'd7);
        cyc(); idle(); #1;
        chk("byp_count_after", 64'(out_count), 64'd0);

        // Mispredict flush with three entries and a concurrent dispatch
        for (int k = 0; k < 3; k++) begin
            disp(1, 0, 64'(k + 1), 1, 0, 64'h10, 5'(k + 24), 1'b0, 8'h0);
            cyc(); idle();
        end
        #1;
        chk("mp_count_pre", 64'(out_count), 64'd3);
        chk("mp_valid_pre", 64'(out_issue_valid), 64'd1);
        disp(1, 0, 64'h77, 1, 0, 64'h78, 5'd30, 1'b0, 8'h0);
        in_rob_is_mispred = 1'b1;
        in_fu_ready       = 1'b1;
        #1;
        chk("mp_valid_masked", 64'(out_issue_valid), 64'd0);
        chk("mp_op1_zero", out_issue_op1_value, 64'd0);
        cyc(); idle(); in_fu_ready = 1'b1; #1;
        chk("mp_count_post", 64'(out_count), 64'd0);
        chk("mp_valid_post", 64'(out_issue_valid), 64'd0);
        cyc(); idle(); #1;
        chk("mp_dispatch_dropped", 64'(out_count), 64'd0);

        // Dispatch and issue in the same cycle, then dual-operand wakeup, then reset
        disp(1, 0, 64'h40, 1, 0, 64'h41, 5'd4, 1'b0, 8'h0);
        cyc(); idle();
        disp(0, 5'd12, 64'd0, 1, 0, 64'h50, 5'd5, 1'b0, 8'h0);
        cyc(); idle(); #1;
        chk("same_count_pre", 64'(out_count), 64'd2);
        disp(0, 5'd12, 64'd0, 0, 5'd12, 64'd0, 5'd6, 1'b0, 8'h0);
        in_fu_ready = 1'b1;
        #1;
        chk("same_issue_dst", 64'(out_issue_dst_rob_index), 64'd4);
        cyc(); idle(); #1;
        chk("same_count_post", 64'(out_count), 64'd2);
        chk("same_none_ready", 64'(out_issue_valid), 64'd0);
        bcast(5'd12, 64'h77);
        cyc(); idle(); in_fu_ready = 1'b1; #1;
        chk("wake_old_dst", 64'(out_issue_dst_rob_index), 64'd5);
        chk("wake_old_op1", out_issue_op1_value, 64'h77);
        chk("wake_old_op2", out_issue_op2_value, 64'h50);
        cyc(); idle(); in_fu_ready = 1'b1; #1;
        chk("wake_both_dst", 64'(out_issue_dst_rob_index), 64'd6);
        chk("wake_both_op1", out_issue_op1_value, 64'h77);
        chk("wake_both_op2", out_issue_op2_value, 64'h77);
        chk("wake_both_count", 64'(out_count), 64'd1);
        in_rst = 1'b1;
        cyc(); idle(); #1;
        chk("rst_mid_count", 64'(out_count), 64'd0);
        chk("rst_mid_valid", 64'(out_issue_valid), 64'd0);
        chk("rst_mid_ready", 64'(out_dispatch_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
